alu_seq_ctrl: RTL

Multi-cycle ALU sequencer built around a single shared WIDTH-bit ripple add/subtract datapath.
- Accepts one operation per start/done handshake: ADD, SUB, MUL (unsigned shift-add) or DIV (unsigned restoring).
- Drives the add/sub unit step by step until the result is ready, then registers the result.
- Sits between the instruction/test driver and the arithmetic datapath; the only owner of the adder.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_seq_ctrl_if.sv | 27 ++
 rtl/alu_addsub.sv | 28 ++
 rtl/alu_seq_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU sequencer: op codes, FSM states, default width.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/result bundle between the instruction driver (master) and the ALU sequencer (slave).
interface alu_seq_ctrl_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, err
  );

endinterface

// File: rtl/alu_addsub.sv
// Combinational ripple add/subtract; in subtract mode cout is the inverted borrow.
module alu_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH:0]   c;

  assign y_eff = y ^ {WIDTH{sub}};

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = sub;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]  = x[i] ^ y_eff[i] ^ c[i];
      c[i+1]  = (x[i] & y_eff[i]) | (c[i] & (x[i] ^ y_eff[i]));
    end
    cout = c[WIDTH];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer sharing one add/sub unit; start/done handshake.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   add_x;
  logic [WIDTH-1:0]   add_y;
  logic               add_sub;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  logic [WIDTH-1:0]   div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   mul_s;
  logic               mul_c;
  logic               last_step;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Partial remainder shifted left with the next dividend bit; a bit falling out of
  // the top means the trial value already exceeds any WIDTH-bit divisor.
  assign div_trial = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
  assign div_ok    = add_cout | acc_hi[WIDTH-1];
  assign mul_s     = acc_lo[0] ? add_sum  : acc_hi;
  assign mul_c     = acc_lo[0] ? add_cout : 1'b0;
  assign last_step = (op_r == OP_ADD) || (op_r == OP_SUB) || (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    case (op_r)
      OP_ADD: begin add_x = a_r;       add_y = b_r;                  end
      OP_SUB: begin add_x = a_r;       add_y = b_r; add_sub = 1'b1;  end
      OP_MUL: begin add_x = acc_hi;    add_y = a_r;                  end
      default: begin add_x = div_trial; add_y = b_r; add_sub = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            op_r   <= bus.op;
            acc_hi <= '0;
            acc_lo <= (bus.op == OP_MUL) ? bus.b : (bus.op == OP_DIV) ? bus.a : '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          case (op_r)
            OP_ADD: begin acc_hi <= {{(WIDTH-1){1'b0}}, add_cout};  acc_lo <= add_sum; end
            OP_SUB: begin acc_hi <= {{(WIDTH-1){1'b0}}, ~add_cout}; acc_lo <= add_sum; end
            OP_MUL: begin
              acc_hi <= {mul_c, mul_s[WIDTH-1:1]};
              acc_lo <= {mul_s[0], acc_lo[WIDTH-1:1]};
            end
            default: begin
              acc_hi <= div_ok ? add_sum : div_trial;
              acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end
          endcase
          cnt <= cnt + CNT_W'(1);
          if (last_step) state <= ST_DONE;
        end
        ST_DONE: begin
          result_q <= {acc_hi, acc_lo};
          err_q    <= (op_r == OP_DIV) && (b_r == '0);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule
